// File: rtl/multu_seq.sv
`default_nettype none
// ============================================================================
// multu_seq : iterative radix-2 shift-add unsigned 32x32->64 multiplier.
// Optional MULTU_EARLY_EXIT_EN ends the operation once no multiplier bits remain.
// Revision  : 1.0
// ============================================================================
module multu_seq (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] multiplicand,
  input  logic [31:0] multiplier,
  input  logic        start,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t      state, state_nx;
  logic        carry, carry_nx;
  logic [31:0] hi_nx, lo_nx;
  logic [31:0] mcand, mcand_nx;
  logic [4:0]  count, count_nx;
  logic        done_nx;
  logic [32:0] sum;
  logic [64:0] shifted;
`ifdef MULTU_EARLY_EXIT_EN
  logic [4:0]  remaining;
  logic [31:0] remaining_mask;
`endif

  assign busy = (state == S_RUN);

  always_comb begin
    state_nx = state;
    carry_nx = carry;
    hi_nx    = hi;
    lo_nx    = lo;
    mcand_nx = mcand;
    count_nx = count;
    done_nx  = 1'b0;
    sum      = {carry, hi} + (lo[0] ? {1'b0, mcand} : 33'd0);
    // lo doubles as the low product half and the unconsumed multiplier bits
    shifted  = {sum, lo} >> 1;
`ifdef MULTU_EARLY_EXIT_EN
    remaining      = 5'd31 - count;
    remaining_mask = (32'd1 << remaining) - 32'd1;
`endif

    if (start) begin
      carry_nx = 1'b0;
      hi_nx    = 32'd0;
      lo_nx    = multiplier;
      mcand_nx = multiplicand;
      count_nx = 5'd0;
      state_nx = S_RUN;
    end else if (state == S_RUN) begin
      {carry_nx, hi_nx, lo_nx} = shifted;
      count_nx = count + 5'd1;
      if (count == 5'd31) begin
        state_nx = S_IDLE;
        done_nx  = 1'b1;
      end
`ifdef MULTU_EARLY_EXIT_EN
      // No multiplier bits left: skip the remaining zero iterations in one shift.
      if ((shifted[31:0] & remaining_mask) == 32'd0) begin
        {hi_nx, lo_nx} = shifted[63:0] >> remaining;
        count_nx = 5'd0;
        state_nx = S_IDLE;
        done_nx  = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      carry <= 1'b0;
      hi    <= 32'd0;
      lo    <= 32'd0;
      mcand <= 32'd0;
      count <= 5'd0;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      carry <= carry_nx;
      hi    <= hi_nx;
      lo    <= lo_nx;
      mcand <= mcand_nx;
      count <= count_nx;
      done  <= done_nx;
    end
  end

endmodule
`default_nettype wire
